// File: rtl/mem_stage_pkg.sv
// Shared pipeline types: ALU opcodes, memory-op encoding and mem-stage FSM states.
`include "gpr.svh"

package mem_stage_pkg;

  localparam int unsigned GprIdxW = `GPR_IDX_W;
  localparam int unsigned XLen    = 64;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpSub  = 4'h1,
    OpAnd  = 4'h2,
    OpOr   = 4'h3,
    OpXor  = 4'h4,
    OpShl  = 4'h5,
    OpShr  = 4'h6,
    OpMul  = 4'h7,
    OpLoad = 4'h8,
    OpStor = 4'h9
  } opcode_t;

  // Encoding 2'b11 is reserved and handled like MemNone.
  typedef enum logic [1:0] {
    MemNone  = 2'b00,
    MemLoad  = 2'b01,
    MemStore = 2'b10,
    MemRsvd  = 2'b11
  } memop_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10
  } state_e;

  function automatic logic is_mem_op(memop_e op);
    return (op == MemLoad) || (op == MemStore);
  endfunction

endpackage

// File: rtl/gpr.svh
// General-purpose register file geometry shared by pipeline stages.
`ifndef GPR_SVH
`define GPR_SVH

`define GPR_IDX_W 4

`endif

// File: rtl/mem_stage.sv
// Memory pipeline stage: forwards ALU results to writeback and sequences one load/store at a time.
// Optional build macro MEM_STAGE_TRACE_EN prints "[MEM]" trace lines for transfers, accepts, writebacks.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               exe_mem,
  input  logic [127:0]       result,
  input  logic [63:0]        rflags,
  input  logic [GprIdxW-1:0] exe_dst,
  input  logic [1:0]         exe_memop,
  input  logic               exe_wide,
  input  logic [63:0]        exe_addr,
  output logic               mem_blocked,
  output logic               mem_req,
  output logic               mem_we,
  output logic [63:0]        mem_addr,
  output logic [63:0]        mem_wdata,
  input  logic               mem_req_ready,
  input  logic               mem_resp_valid,
  input  logic [63:0]        mem_rdata,
  output logic               wb_en,
  output logic               wb_hi_en,
  output logic [GprIdxW-1:0] wb_reg,
  output logic [63:0]        wb_data,
  output logic [63:0]        wb_data_hi,
  output logic [63:0]        wb_rflags
);

  state_e             state_q;
  memop_e             op_q;
  logic [GprIdxW-1:0] dst_q;
  logic [63:0]        flags_q;

  logic               mem_req_q;
  logic               mem_we_q;
  logic [63:0]        mem_addr_q;
  logic [63:0]        mem_wdata_q;
  logic               wb_en_q;
  logic               wb_hi_en_q;
  logic [GprIdxW-1:0] wb_reg_q;
  logic [63:0]        wb_data_q;
  logic [63:0]        wb_data_hi_q;
  logic [63:0]        wb_rflags_q;

  memop_e exe_op;
  logic   xfer;

  assign exe_op      = memop_e'(exe_memop);
  assign mem_blocked = (state_q == StReq) || (state_q == StWait);
  assign xfer        = exe_mem && !mem_blocked;

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wb_en      = wb_en_q;
  assign wb_hi_en   = wb_hi_en_q;
  assign wb_reg     = wb_reg_q;
  assign wb_data    = wb_data_q;
  assign wb_data_hi = wb_data_hi_q;
  assign wb_rflags  = wb_rflags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= MemNone;
      dst_q        <= '0;
      flags_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wb_en_q      <= 1'b0;
      wb_hi_en_q   <= 1'b0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
      wb_data_hi_q <= '0;
      wb_rflags_q  <= '0;
    end else begin
      // Writeback strobes are single-cycle pulses.
      wb_en_q    <= 1'b0;
      wb_hi_en_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (xfer) begin
            if (is_mem_op(exe_op)) begin
              op_q        <= exe_op;
              dst_q       <= exe_dst;
              flags_q     <= rflags;
              mem_addr_q  <= exe_addr;
              mem_wdata_q <= result[63:0];
              mem_req_q   <= 1'b1;
              mem_we_q    <= (exe_op == MemStore);
              state_q     <= StReq;
            end else begin
              wb_en_q      <= 1'b1;
              wb_hi_en_q   <= exe_wide;
              wb_reg_q     <= exe_dst;
              wb_data_q    <= result[63:0];
              wb_data_hi_q <= result[127:64];
              wb_rflags_q  <= rflags;
            end
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (op_q == MemStore) begin
              // Stores write no register but still publish their flags.
              wb_reg_q    <= dst_q;
              wb_rflags_q <= flags_q;
              state_q     <= StIdle;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (mem_resp_valid) begin
            wb_en_q     <= 1'b1;
            wb_reg_q    <= dst_q;
            wb_data_q   <= mem_rdata;
            wb_rflags_q <= flags_q;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MEM_STAGE_TRACE_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (xfer) begin
        $display("[MEM] xfer op=%0d dst=%0d res=%h addr=%h", exe_memop, exe_dst, result,
                 exe_addr);
      end
      if ((state_q == StReq) && mem_req_ready) begin
        $display("[MEM] accept we=%0b addr=%h wdata=%h", mem_we_q, mem_addr_q, mem_wdata_q);
      end
      if (wb_en_q) begin
        $display("[MEM] wb reg=%0d data=%h hi_en=%0b hi=%h", wb_reg_q, wb_data_q, wb_hi_en_q,
                 wb_data_hi_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed stimulus pushes expectations, negedge monitor checks.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         exe_mem;
  logic [127:0] result;
  logic [63:0]  rflags;
  logic [3:0]   exe_dst;
  logic [1:0]   exe_memop;
  logic         exe_wide;
  logic [63:0]  exe_addr;
  logic         mem_blocked;
  logic         mem_req;
  logic         mem_we;
  logic [63:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [63:0]  mem_rdata;
  logic         wb_en;
  logic         wb_hi_en;
  logic [3:0]   wb_reg;
  logic [63:0]  wb_data;
  logic [63:0]  wb_data_hi;
  logic [63:0]  wb_rflags;

  typedef struct {
    logic [3:0]  rg;
    logic [63:0] data;
    logic        hi_en;
    logic [63:0] data_hi;
    logic [63:0] flags;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .exe_mem        (exe_mem),
    .result         (result),
    .rflags         (rflags),
    .exe_dst        (exe_dst),
    .exe_memop      (exe_memop),
    .exe_wide       (exe_wide),
    .exe_addr       (exe_addr),
    .mem_blocked    (mem_blocked),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .wb_en          (wb_en),
    .wb_hi_en       (wb_hi_en),
    .wb_reg         (wb_reg),
    .wb_data        (wb_data),
    .wb_data_hi     (wb_data_hi),
    .wb_rflags      (wb_rflags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_blocked"}, 128'(mem_blocked), 128'(0));
    chk({name, "_req"},     128'({mem_req, mem_we, wb_en, wb_hi_en}), 128'(0));
    chk({name, "_mem_bus"}, {mem_addr, mem_wdata}, 128'(0));
    chk({name, "_wb_bus"},  {wb_data, wb_data_hi}, 128'(0));
    chk({name, "_wb_misc"}, 128'({wb_reg, wb_rflags}), 128'(0));
  endtask

  task automatic push_wb(input logic [3:0] rg, input logic [63:0] data, input logic hi_en,
                         input logic [63:0] data_hi, input logic [63:0] flags);
    wb_exp_t e;
    e.rg = rg; e.data = data; e.hi_en = hi_en; e.data_hi = data_hi; e.flags = flags;
    wb_q.push_back(e);
  endtask

  task automatic push_mem(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    mem_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] op, input logic [127:0] res, input logic [3:0] dst,
                       input logic wide, input logic [63:0] addr, input logic [63:0] flg);
    exe_mem = 1'b1; exe_memop = op; result = res; exe_dst = dst;
    exe_wide = wide; exe_addr = addr; rflags = flg;
  endtask

  // Monitor: every writeback pulse and every memory accept must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_en) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected", 128'(wb_en), 128'(0));
        end else begin
          wb_exp_t e;
          e = wb_q.pop_front();
          chk("wb_reg",   128'(wb_reg), 128'(e.rg));
          chk("wb_data",  128'(wb_data), 128'(e.data));
          chk("wb_hi_en", 128'(wb_hi_en), 128'(e.hi_en));
          chk("wb_flags", 128'(wb_rflags), 128'(e.flags));
          if (e.hi_en) chk("wb_data_hi", 128'(wb_data_hi), 128'(e.data_hi));
        end
      end
      if (mem_req && mem_req_ready) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexpected", 128'(mem_req), 128'(0));
        end else begin
          mem_exp_t m;
          m = mem_q.pop_front();
          chk("mem_we",   128'(mem_we), 128'(m.we));
          chk("mem_addr", 128'(mem_addr), 128'(m.addr));
          if (m.we) chk("mem_wdata", 128'(mem_wdata), 128'(m.wdata));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; exe_mem = 1'b0; result = '0; rflags = '0; exe_dst = '0;
    exe_memop = 2'b00; exe_wide = 1'b0; exe_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    cyc(); cyc();
    chk_all_zero("reset");
    reset = 1'b0;
    cyc();

    // Non-memory transfer
    issue(2'b00, 128'h5, 4'd3, 1'b0, 64'h0, 64'h11);
    push_wb(4'd3, 64'h5, 1'b0, 64'h0, 64'h11);
    chk("nm_blocked_pre", 128'(mem_blocked), 128'(0));
    cyc();
    exe_mem = 1'b0;
    chk("nm_wb_en", 128'(wb_en), 128'(1));
    chk("nm_blocked_post", 128'(mem_blocked), 128'(0));
    cyc();
    chk("nm_wb_pulse", 128'(wb_en), 128'(0));

    // Wide op
    issue(2'b00, {64'hA, 64'hB}, 4'd5, 1'b1, 64'h0, 64'h22);
    push_wb(4'd5, 64'hB, 1'b1, 64'hA, 64'h22);
    cyc();
    exe_mem = 1'b0; exe_wide = 1'b0;
    cyc();
    chk("wide_hi_pulse", 128'(wb_hi_en), 128'(0));

    // Load: ready delayed 3 cycles, stray resp during REQ must be ignored
    issue(2'b01, 128'h99, 4'd7, 1'b0, 64'h1000, 64'h33);
    push_mem(1'b0, 64'h1000, 64'h0);
    cyc();
    exe_mem = 1'b0; exe_addr = 64'hFFFF;
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid = (i == 0); mem_rdata = 64'hBAD;
      chk("ld_req_blocked", 128'({mem_blocked, mem_req, mem_we}), 128'(3'b110));
      chk("ld_addr_hold", 128'(mem_addr), 128'(64'h1000));
      cyc();
    end
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    chk("ld_wait", 128'({mem_blocked, mem_req}), 128'(2'b10));
    cyc();
    chk("ld_wait2", 128'({mem_blocked, wb_en}), 128'(2'b10));
    mem_resp_valid = 1'b1; mem_rdata = 64'hDEAD;
    push_wb(4'd7, 64'hDEAD, 1'b0, 64'h0, 64'h33);
    cyc();
    mem_resp_valid = 1'b0;
    chk("ld_done", 128'({mem_blocked, wb_en, wb_hi_en}), 128'(3'b010));
    cyc();
    chk("ld_wb_pulse", 128'(wb_en), 128'(0));

    // Store: data held until ready, no register write, flags published
    issue(2'b10, 128'h7, 4'd2, 1'b0, 64'h2000, 64'h44);
    push_mem(1'b1, 64'h2000, 64'h7);
    cyc();
    exe_mem = 1'b0; result = 128'hFACE; exe_addr = 64'h0;
    for (int i = 0; i < 2; i++) begin
      chk("st_req", 128'({mem_blocked, mem_req, mem_we}), 128'(3'b111));
      chk("st_wdata_hold", 128'(mem_wdata), 128'(64'h7));
      cyc();
    end
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    chk("st_done", 128'({mem_blocked, mem_req, mem_we, wb_en}), 128'(0));
    chk("st_flags", 128'(wb_rflags), 128'(64'h44));

    // Reset during WAIT abandons the load; late response is ignored
    issue(2'b01, 128'h0, 4'd4, 1'b0, 64'h3000, 64'h55);
    push_mem(1'b0, 64'h3000, 64'h0);
    cyc();
    exe_mem = 1'b0; mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_all_zero("rst_wait");
    mem_resp_valid = 1'b1; mem_rdata = 64'hBEEF;
    cyc();
    mem_resp_valid = 1'b0;
    chk_all_zero("rst_late_resp");

    // Reset dominates a simultaneous transfer
    issue(2'b00, 128'h77, 4'd6, 1'b1, 64'h0, 64'h66);
    reset = 1'b1;
    cyc();
    reset = 1'b0; exe_mem = 1'b0; exe_wide = 1'b0;
    chk_all_zero("rst_xfer");

    // Load writeback coinciding with a new non-memory transfer
    issue(2'b01, 128'h0, 4'd8, 1'b0, 64'h4000, 64'h88);
    push_mem(1'b0, 64'h4000, 64'h0);
    cyc();
    exe_mem = 1'b0; mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h1234;
    push_wb(4'd8, 64'h1234, 1'b0, 64'h0, 64'h88);
    cyc();
    mem_resp_valid = 1'b0;
    issue(2'b00, 128'h55, 4'd9, 1'b0, 64'h0, 64'h99);
    push_wb(4'd9, 64'h55, 1'b0, 64'h0, 64'h99);
    chk("b2b_accept", 128'({wb_en, mem_blocked}), 128'(2'b10));
    cyc();
    exe_mem = 1'b0;
    chk("b2b_second", 128'({wb_en, wb_reg}), 128'({1'b1, 4'd9}));
    cyc(); cyc();

    chk("wb_queue_drained", 128'(wb_q.size()), 128'(0));
    chk("mem_queue_drained", 128'(mem_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 exe_mem  in  1  execute-stage valid; the operand bundle below is meaningful only when this is high.
REQ-004 result  in  128  execute result; [63:0] is the primary value, [127:64] is the high half for wide ops.
REQ-005 rflags  in  64  flags produced by the execute op.
REQ-006 exe_dst  in  4  destination GPR index.
REQ-007 exe_memop  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
REQ-008 exe_wide  in  1  when high, result[127:64] is also written back.
REQ-009 exe_addr  in  64  memory address for load/store.
REQ-010 mem_blocked  out  1  backpressure to execute; execute holds its outputs while high.
REQ-011 mem_req / mem_we / mem_addr[64] / mem_wdata[64]  out  memory request, write-enable, address, store data.
REQ-012 mem_req_ready  in  1  memory accepts the request on an edge where mem_req=1.
REQ-013 mem_resp_valid / mem_rdata[64]  in  load response pulse and data.
REQ-014 wb_en / wb_hi_en  out  1  writeback strobes for primary and high half.
REQ-015 wb_reg[4] / wb_data[64] / wb_data_hi[64] / wb_rflags[64]  out  writeback payload.

Function
REQ-016 Transfer SHALL occur exactly on a posedge where exe_mem=1 and mem_blocked=0.
REQ-017 FSM states SHALL be IDLE, REQ, WAIT; mem_blocked SHALL be combinational, high iff state is REQ or WAIT.
REQ-018 IDLE, non-memory transfer: state stays IDLE; wb_en=1 for the next cycle only, wb_data=result[63:0], wb_reg=exe_dst, wb_rflags=rflags; wb_hi_en=exe_wide with wb_data_hi=result[127:64].
REQ-019 IDLE, load or store transfer: latch address, data (result[63:0]), dst, flags, and op; go to REQ.
REQ-020 REQ: mem_req=1 and mem_we=1 for a store; on a mem_req_ready edge, a load goes to WAIT and a store goes to IDLE with a one-cycle wb_en=0 (no register write); the flag update for a store SHALL be delivered as wb_rflags with wb_en=0.
REQ-021 WAIT: on a mem_resp_valid edge, wb_en=1 for one cycle with wb_data=mem_rdata and wb_reg=latched dst; return to IDLE.
REQ-022 mem_resp_valid outside WAIT SHALL be ignored; mem_req_ready outside REQ SHALL be ignored.
REQ-023 A new transfer SHALL be accepted in the same cycle a load writeback is presented (back-to-back ops with zero bubble).
REQ-024 wb_hi_en SHALL be 0 for loads and stores.
REQ-025 mem_addr and mem_wdata SHALL remain stable from entry to REQ until accepted.

Reset
REQ-026 reset SHALL force state to IDLE and clear every output (mem_req, mem_we, wb_en, wb_hi_en, and all data, address, and flag buses) to 0 on the next edge.
REQ-027 Reset mid-REQ or mid-WAIT SHALL abandon the op; a late mem_resp_valid SHALL produce no writeback.
REQ-028 reset SHALL dominate a simultaneous transfer, mem_req_ready, or mem_resp_valid.

Configuration
REQ-029 Macro MEM_STAGE_TRACE_EN: when defined, each transfer, memory accept, and writeback SHALL emit one $display line prefixed "[MEM]"; when undefined, there is no display code and behaviour is otherwise identical.

Structure
REQ-030 The memop encoding enum and the state enum SHALL live in the shared package alongside opcode_t; the GPR index width SHALL come from gpr.svh.
REQ-031 The module SHALL be a single module with no sub-modules; the FSM and the writeback register stay inline.

Verification
REQ-032 Non-memory transfer: exe_mem=1, memop=00, result=0x5, dst=3 -> next cycle wb_en=1, wb_reg=3, wb_data=0x5, and mem_blocked stays 0.
REQ-033 Wide op: exe_wide=1, result={0xA,0xB} -> wb_hi_en=1, wb_data_hi=0xA, wb_data=0xB.
REQ-034 Load: addr=0x1000, mem_req_ready delayed 3 cycles, resp 2 cycles later with 0xDEAD -> mem_blocked high throughout; wb_data=0xDEAD, one-cycle wb_en.
REQ-035 Store: addr=0x2000, data=0x7 -> mem_req=1, mem_we=1, and mem_wdata=0x7 held until ready; wb_en stays 0; return to IDLE.
REQ-036 Reset asserted during WAIT, then mem_resp_valid -> no wb_en pulse; all outputs 0.
REQ-037 Load writeback coinciding with a new non-memory transfer -> both writebacks appear on consecutive cycles in order, with none lost.
